alu_issue_seq: RTL and testbench

- Instruction sequencer driving the receiver datapath ALU from the issuing side.
- Accepts 32-bit instruction words on a valid/ready stream and decodes them into ALU opcode, shift and operands from a local register file.
- Writes the combinational ALU result back into the register file and emits it on a result stream.
- Sits between the control/config front end and the ALU; owns all ALU input timing.

---
 rtl/alu_issue_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_issue_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// -----------------------------------------------------------------------------
// alu_issue_seq
//
// Instruction sequencer that feeds the receiver-datapath ALU. It takes 32-bit
// instruction words from a valid/ready stream, decodes them into opcode, shift
// and operands read from a local register file, and drives registered ALU
// inputs. The ALU result, which is combinational, is written back into the
// register file and presented on a result stream at the end of the EXEC cycle.
//
// Pipeline:
//   ISSUE - on an accept edge the decoded instruction is registered onto the
//           alu_* outputs and the EXEC stage becomes valid.
//   EXEC  - alu_* stay stable for the whole cycle. At the closing edge the ALU
//           result is written to regfile[rd] and loaded into res_data/res_rd.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ins_valid/ins_ready   instruction stream handshake
//   ins_data              [31:24] opcode, [23:19] shift, [18:16] rd,
//                         [15:13] ra, [12:10] rb, [9] imm_en, [8:0] imm9
//   alu_opcode/a/b/shift  registered ALU inputs
//   alu_result            combinational ALU output
//   res_valid/res_ready   result stream handshake
//   res_data, res_rd      written-back value and its destination register
//   dbg_addr, dbg_data    combinational register file read port
// -----------------------------------------------------------------------------
module alu_issue_seq #(
    parameter int                N       = 16,
    parameter int                C       = 8,
    parameter int                S       = 5,
    parameter int                R       = 8,
    parameter logic [C-1:0]      ALU_NOP = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 ins_valid,
    output logic                 ins_ready,
    input  logic [31:0]          ins_data,

    output logic [C-1:0]         alu_opcode,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic [S-1:0]         alu_shift,
    input  logic [N-1:0]         alu_result,

    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [N-1:0]         res_data,
    output logic [$clog2(R)-1:0] res_rd,

    input  logic [$clog2(R)-1:0] dbg_addr,
    output logic [N-1:0]         dbg_data
);

    localparam int RW = $clog2(R);

    // -------------------------------------------------------------------------
    // Instruction decode
    // -------------------------------------------------------------------------
    logic [C-1:0]  dec_opcode;
    logic [S-1:0]  dec_shift;
    logic [RW-1:0] dec_rd;
    logic [RW-1:0] dec_ra;
    logic [RW-1:0] dec_rb;
    logic          dec_imm_en;
    logic [8:0]    dec_imm9;
    logic [N-1:0]  dec_imm_ext;

    assign dec_opcode  = ins_data[31:24];
    assign dec_shift   = ins_data[23:19];
    assign dec_rd      = ins_data[18:16];
    assign dec_ra      = ins_data[15:13];
    assign dec_rb      = ins_data[12:10];
    assign dec_imm_en  = ins_data[9];
    assign dec_imm9    = ins_data[8:0];
    // imm9 is two's complement; its sign bit is replicated up to N bits.
    assign dec_imm_ext = {{(N-9){dec_imm9[8]}}, dec_imm9};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [N-1:0]  regs_q [R];

    logic [C-1:0]  alu_opcode_q, alu_opcode_d;
    logic [N-1:0]  alu_a_q,      alu_a_d;
    logic [N-1:0]  alu_b_q,      alu_b_d;
    logic [S-1:0]  alu_shift_q,  alu_shift_d;
    logic          exec_valid_q, exec_valid_d;
    logic [RW-1:0] exec_rd_q,    exec_rd_d;
    logic          res_valid_q,  res_valid_d;
    logic [N-1:0]  res_data_q,   res_data_d;
    logic [RW-1:0] res_rd_q,     res_rd_d;

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    logic          stall;
    logic          accept;
    logic          exec_wr;
    logic          wb_en;
    logic          fwd_a;
    logic          fwd_b;
    logic [N-1:0]  opnd_a;
    logic [N-1:0]  opnd_b;

    // A result that has not been taken freezes the whole pipe: EXEC cannot
    // retire into res_data, so nothing new may enter EXEC either.
    assign stall     = res_valid_q && !res_ready;
    assign ins_ready = !stall;
    assign accept    = ins_valid && ins_ready;

    // A NOP occupies EXEC but never writes back.
    assign exec_wr   = exec_valid_q && (alu_opcode_q != ALU_NOP);
    assign wb_en     = exec_wr && !stall;

    // Forwarding: an instruction accepted while EXEC is about to write a
    // register it reads takes the live ALU result instead of the stale file
    // entry. Accept implies !stall, so the write lands on the same edge.
    assign fwd_a     = exec_wr && (exec_rd_q == dec_ra);
    assign fwd_b     = exec_wr && !dec_imm_en && (exec_rd_q == dec_rb);

    assign opnd_a    = fwd_a ? alu_result : regs_q[dec_ra];
    assign opnd_b    = dec_imm_en ? dec_imm_ext
                     : (fwd_b ? alu_result : regs_q[dec_rb]);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_shift_d  = alu_shift_q;
        exec_valid_d = exec_valid_q;
        exec_rd_d    = exec_rd_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_rd_d     = res_rd_q;

        if (!stall) begin
            // ISSUE stage
            if (accept) begin
                alu_opcode_d = dec_opcode;
                alu_a_d      = opnd_a;
                alu_b_d      = opnd_b;
                alu_shift_d  = dec_shift;
                exec_valid_d = 1'b1;
                exec_rd_d    = dec_rd;
            end else begin
                // Idle: ALU sees NOP, operands keep their last values so the
                // ALU inputs do not toggle needlessly.
                alu_opcode_d = ALU_NOP;
                exec_valid_d = 1'b0;
            end

            // EXEC retirement into the result register
            if (exec_wr) begin
                res_valid_d = 1'b1;
                res_data_d  = alu_result;
                res_rd_d    = exec_rd_q;
            end else if (res_valid_q && res_ready) begin
                res_valid_d = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode_q <= ALU_NOP;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_shift_q  <= '0;
            exec_valid_q <= 1'b0;
            exec_rd_q    <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_rd_q     <= '0;
        end else begin
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_shift_q  <= alu_shift_d;
            exec_valid_q <= exec_valid_d;
            exec_rd_q    <= exec_rd_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_rd_q     <= res_rd_d;
        end
    end

    // -------------------------------------------------------------------------
    // Register file: one write port (EXEC writeback), asynchronous clear.
    // Reads are combinational, so a read of the entry being written this cycle
    // returns the old value; the new one appears after the edge.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < R; gi++) begin : g_regs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs_q[gi] <= '0;
            end else if (wb_en && (exec_rd_q == RW'(gi))) begin
                regs_q[gi] <= alu_result;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_shift  = alu_shift_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_rd     = res_rd_q;
    assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_seq.sv
// -----------------------------------------------------------------------------
// Directed bench for alu_issue_seq. A small behavioural ALU closes the loop on
// alu_result; every expected value below is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_alu_issue_seq;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_ADD_I = 8'h01;
    localparam logic [7:0] OP_OR_I  = 8'h04;
    localparam logic [7:0] OP_XOR_I = 8'h05;
    localparam logic [7:0] OP_UNK   = 8'hEE;

    logic        clk;
    logic        rst_n;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_data;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_shift;
    logic [15:0] alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_rd;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_vec = 0;
    int n_err = 0;
    int n_hs  = 0;
    int hs_start;

    alu_issue_seq #(.N(16), .C(8), .S(5), .R(8), .ALU_NOP(OP_NOP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins_data   (ins_data),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_shift  (alu_shift),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; shift is not used by this opcode subset.
    always_comb begin
        case (alu_opcode)
            OP_ADD_I: alu_result = alu_a + alu_b;
            OP_OR_I:  alu_result = alu_a | alu_b;
            OP_XOR_I: alu_result = alu_a ^ alu_b;
            default:  alu_result = 16'h0000;
        endcase
    end

    // Result-stream handshakes, to confirm one writeback per instruction.
    always @(posedge clk) begin
        if (rst_n && res_valid && res_ready) n_hs <= n_hs + 1;
    end

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [4:0] sh,
                                        input logic [2:0] rd, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic imm_en,
                                        input logic [8:0] imm9);
        return {op, sh, rd, ra, rb, imm_en, imm9};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %h expected %h", n_vec, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_check(input string tag, input logic [2:0] idx, input logic [15:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    initial begin
        rst_n     = 1'b0;
        ins_valid = 1'b0;
        ins_data  = 32'h0;
        res_ready = 1'b1;
        dbg_addr  = 3'd0;

        // ---------------- reset state ----------------
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("rst_dbg_r%0d", i), {16'h0, dbg_data}, 32'h0);
        end
        check("rst_res_valid", {31'h0, res_valid}, 32'h0);
        check("rst_alu_opcode", {24'h0, alu_opcode}, {24'h0, OP_NOP});
        check("rst_alu_a", {16'h0, alu_a}, 32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- load r1, r2 with OR immediate ----------------
        ins_valid = 1'b1;
        ins_data  = enc(OP_OR_I, 5'd0, 3'd1, 3'd0, 3'd0, 1'b1, 9'h005);
        #1;
        check("ld_ins_ready", {31'h0, ins_ready}, 32'h1);
        tick();
        check("ld1_alu_opcode", {24'h0, alu_opcode}, {24'h0, OP_OR_I});
        check("ld1_alu_b", {16'h0, alu_b}, 32'h0005);
        ins_data = enc(OP_OR_I, 5'd0, 3'd2, 3'd0, 3'd0, 1'b1, 9'h1FF);
        tick();
        check("ld1_res_valid", {31'h0, res_valid}, 32'h1);
        check("ld1_res_data", {16'h0, res_data}, 32'h0005);
        check("ld1_res_rd", {29'h0, res_rd}, 32'h1);
        check("ld2_alu_b_sext", {16'h0, alu_b}, 32'hFFFF);
        ins_valid = 1'b0;
        tick();
        check("ld2_res_data", {16'h0, res_data}, 32'hFFFF);
        check("ld2_res_rd", {29'h0, res_rd}, 32'h2);
        dbg_check("ld_dbg_r1", 3'd1, 16'h0005);
        dbg_check("ld_dbg_r2", 3'd2, 16'hFFFF);
        tick();
        check("ld_res_valid_clr", {31'h0, res_valid}, 32'h0);
        check("ld_idle_opcode", {24'h0, alu_opcode}, {24'h0, OP_NOP});

        // ---------------- back-to-back with forwarding ----------------
        ins_valid = 1'b1;
        ins_data  = enc(OP_ADD_I, 5'd3, 3'd3, 3'd1, 3'd1, 1'b0, 9'h000);
        tick();
        check("fw_alu_shift", {27'h0, alu_shift}, 32'h3);
        ins_data = enc(OP_ADD_I, 5'd0, 3'd4, 3'd3, 3'd3, 1'b0, 9'h000);
        tick();
        check("fw_r3_res_valid", {31'h0, res_valid}, 32'h1);
        check("fw_r3_res_data", {16'h0, res_data}, 32'h000A);
        check("fw_r3_res_rd", {29'h0, res_rd}, 32'h3);
        check("fw_alu_a", {16'h0, alu_a}, 32'h000A);
        check("fw_alu_b", {16'h0, alu_b}, 32'h000A);
        ins_valid = 1'b0;
        tick();
        check("fw_r4_res_valid", {31'h0, res_valid}, 32'h1);
        check("fw_r4_res_data", {16'h0, res_data}, 32'h0014);
        check("fw_r4_res_rd", {29'h0, res_rd}, 32'h4);
        check("idle_alu_a_hold", {16'h0, alu_a}, 32'h000A);
        dbg_check("fw_dbg_r3", 3'd3, 16'h000A);
        dbg_check("fw_dbg_r4", 3'd4, 16'h0014);
        tick();

        // ---------------- backpressure ----------------
        hs_start  = n_hs;
        res_ready = 1'b0;
        ins_valid = 1'b1;
        ins_data  = enc(OP_XOR_I, 5'd0, 3'd6, 3'd1, 3'd0, 1'b1, 9'h003);
        tick();
        ins_data = enc(OP_ADD_I, 5'd0, 3'd7, 3'd1, 3'd2, 1'b0, 9'h000);
        tick();
        check("bp_res_valid", {31'h0, res_valid}, 32'h1);
        check("bp_res_data0", {16'h0, res_data}, 32'h0006);
        ins_data = enc(OP_OR_I, 5'd0, 3'd5, 3'd0, 3'd0, 1'b1, 9'h021);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_ins_ready_c%0d", i), {31'h0, ins_ready}, 32'h0);
            tick();
            check($sformatf("bp_res_data_c%0d", i), {16'h0, res_data}, 32'h0006);
            check($sformatf("bp_res_rd_c%0d", i), {29'h0, res_rd}, 32'h6);
            check($sformatf("bp_alu_opcode_c%0d", i), {24'h0, alu_opcode}, {24'h0, OP_ADD_I});
            check($sformatf("bp_alu_a_c%0d", i), {16'h0, alu_a}, 32'h0005);
            check($sformatf("bp_alu_b_c%0d", i), {16'h0, alu_b}, 32'hFFFF);
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'h0, ins_ready}, 32'h1);
        tick();
        check("bp_r7_res_data", {16'h0, res_data}, 32'h0004);
        check("bp_r7_res_rd", {29'h0, res_rd}, 32'h7);
        check("bp_or_opcode", {24'h0, alu_opcode}, {24'h0, OP_OR_I});
        ins_valid = 1'b0;
        tick();
        check("bp_r5_res_data", {16'h0, res_data}, 32'h0021);
        check("bp_r5_res_rd", {29'h0, res_rd}, 32'h5);
        tick();
        check("bp_res_valid_clr", {31'h0, res_valid}, 32'h0);
        check("bp_handshakes", 32'(n_hs - hs_start), 32'd3);
        dbg_check("bp_dbg_r6", 3'd6, 16'h0006);
        dbg_check("bp_dbg_r7", 3'd7, 16'h0004);
        dbg_check("bp_dbg_r5", 3'd5, 16'h0021);

        // ---------------- reset during EXEC ----------------
        ins_valid = 1'b1;
        ins_data  = enc(OP_XOR_I, 5'd0, 3'd5, 3'd1, 3'd0, 1'b1, 9'h003);
        tick();
        ins_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mrst_res_valid", {31'h0, res_valid}, 32'h0);
        check("mrst_alu_opcode", {24'h0, alu_opcode}, {24'h0, OP_NOP});
        dbg_check("mrst_dbg_r5", 3'd5, 16'h0000);
        dbg_check("mrst_dbg_r1", 3'd1, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst_post_res_valid", {31'h0, res_valid}, 32'h0);
        dbg_check("mrst_post_dbg_r5", 3'd5, 16'h0000);
        tick();
        check("mrst_post2_res_valid", {31'h0, res_valid}, 32'h0);

        // ---------------- NOP and unknown opcode ----------------
        ins_valid = 1'b1;
        ins_data  = enc(OP_OR_I, 5'd0, 3'd1, 3'd0, 3'd0, 1'b1, 9'h005);
        tick();
        ins_valid = 1'b0;
        tick();
        check("nop_prep_res_data", {16'h0, res_data}, 32'h0005);
        tick();
        ins_valid = 1'b1;
        ins_data  = enc(OP_NOP, 5'd0, 3'd1, 3'd0, 3'd0, 1'b1, 9'h01F);
        tick();
        check("nop_alu_opcode", {24'h0, alu_opcode}, {24'h0, OP_NOP});
        check("nop_ex_res_valid", {31'h0, res_valid}, 32'h0);
        ins_valid = 1'b0;
        tick();
        check("nop_res_valid", {31'h0, res_valid}, 32'h0);
        dbg_check("nop_dbg_r1", 3'd1, 16'h0005);

        ins_valid = 1'b1;
        ins_data  = enc(OP_UNK, 5'd0, 3'd1, 3'd1, 3'd1, 1'b0, 9'h000);
        tick();
        check("unk_alu_opcode", {24'h0, alu_opcode}, {24'h0, OP_UNK});
        ins_valid = 1'b0;
        tick();
        check("unk_res_valid", {31'h0, res_valid}, 32'h1);
        check("unk_res_data", {16'h0, res_data}, 32'h0000);
        dbg_check("unk_dbg_r1", 3'd1, 16'h0000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
